// File: rtl/writeback_stage_nlane_pkg.sv
// Shared flag indices, squash FSM states and sizing helper for the N-lane writeback stage.
package wb_pkg;

   localparam int FLG_MISPRED = 0;
   localparam int FLG_DEST    = 4;
   localparam int FLG_COND    = 5;

   typedef enum logic {
      IDLE   = 1'b0,
      SQUASH = 1'b1
   } squashState_e;

   // A single checkpoint still needs a one-bit index so the ports never collapse to zero width.
   function automatic int ckptLog(input int ckpt);
      return (ckpt > 1) ? $clog2(ckpt) : 1;
   endfunction

endpackage

// File: rtl/writeback_stage_nlane_if.sv
// Per-lane execute result bus feeding the writeback stage; the producer drives, the stage listens.
interface writeback_stage_nlane_if #(
   parameter int NUM_LANES = 4,
   parameter int CKPT      = 4,
   parameter int FLAGS_W   = 6,
   parameter int PHYS_W    = 7,
   parameter int AL_W      = 7,
   parameter int IQ_W      = 5,
   parameter int DATA_W    = 32
);

   logic [NUM_LANES-1:0]              valid;
   logic [NUM_LANES-1:0][CKPT-1:0]    mask;
   logic [NUM_LANES-1:0][FLAGS_W-1:0] flags;
   logic [NUM_LANES-1:0][PHYS_W-1:0]  phys;
   logic [NUM_LANES-1:0][AL_W-1:0]    al;
   logic [NUM_LANES-1:0][IQ_W-1:0]    iq;
   logic [NUM_LANES-1:0][DATA_W-1:0]  data;

   modport master (output valid, mask, flags, phys, al, iq, data);
   modport slave  (input  valid, mask, flags, phys, al, iq, data);

endinterface

// File: rtl/writeback_stage_nlane_lane.sv
// One lane's result register: drops arrivals dependent on a squashed checkpoint and clears resolved mask bits.
module wb_lane_reg #(
   parameter int CKPT    = 4,
   parameter int FLAGS_W = 6,
   parameter int PHYS_W  = 7,
   parameter int AL_W    = 7,
   parameter int IQ_W    = 5,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               valid_i,
   input  logic [CKPT-1:0]    mask_i,
   input  logic [FLAGS_W-1:0] flags_i,
   input  logic [PHYS_W-1:0]  phys_i,
   input  logic [AL_W-1:0]    al_i,
   input  logic [IQ_W-1:0]    iq_i,
   input  logic [DATA_W-1:0]  data_i,
   input  logic [CKPT-1:0]    clrMask_i,
   input  logic [CKPT-1:0]    dropMask_i,
   output logic               valid_o,
   output logic [CKPT-1:0]    mask_o,
   output logic [FLAGS_W-1:0] flags_o,
   output logic [PHYS_W-1:0]  phys_o,
   output logic [AL_W-1:0]    al_o,
   output logic [IQ_W-1:0]    iq_o,
   output logic [DATA_W-1:0]  data_o
);

   logic               valid_q, valid_d;
   logic [CKPT-1:0]    mask_q, mask_d;
   logic [FLAGS_W-1:0] flags_q, flags_d;
   logic [PHYS_W-1:0]  phys_q, phys_d;
   logic [AL_W-1:0]    al_q, al_d;
   logic [IQ_W-1:0]    iq_q, iq_d;
   logic [DATA_W-1:0]  data_q, data_d;

   // The filter looks at the raw arrival mask; the resolved-bit clear applies to whatever ends up stored.
   always_comb begin
      valid_d = valid_i & ~(|(mask_i & dropMask_i));
      mask_d  = mask_q & ~clrMask_i;
      flags_d = flags_q;
      phys_d  = phys_q;
      al_d    = al_q;
      iq_d    = iq_q;
      data_d  = data_q;
      if (valid_i) begin
         mask_d  = mask_i & ~clrMask_i;
         flags_d = flags_i;
         phys_d  = phys_i;
         al_d    = al_i;
         iq_d    = iq_i;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         mask_q  <= '0;
         flags_q <= '0;
         phys_q  <= '0;
         al_q    <= '0;
         iq_q    <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         mask_q  <= mask_d;
         flags_q <= flags_d;
         phys_q  <= phys_d;
         al_q    <= al_d;
         iq_q    <= iq_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign mask_o  = mask_q;
   assign flags_o = flags_q;
   assign phys_o  = phys_q;
   assign al_o    = al_q;
   assign iq_o    = iq_q;
   assign data_o  = data_q;

endmodule

// File: rtl/writeback_stage_nlane.sv
// N-lane writeback stage: registers lane results, resolves branches, squashes dependents and counts writebacks.
module writeback_stage_nlane
   import wb_pkg::*;
#(
   parameter int NUM_LANES     = 4,
   parameter int CTRL_LANE     = 2,
   parameter int LSU_LANE      = 3,
   parameter int DATA_W        = 32,
   parameter int PHYS_W        = 7,
   parameter int AL_W          = 7,
   parameter int IQ_W          = 5,
   parameter int CKPT          = 4,
   parameter int CTI_W         = 4,
   parameter int PC_W          = 32,
   parameter int FLAGS_W       = 6,
   parameter int WB_FLAGS_W    = 4,
   parameter int SQUASH_CYCLES = 2,
   parameter int CNT_W         = 16,
   localparam int CKPT_LOG     = ckptLog(CKPT)
) (
   input  logic                                       clk,
   input  logic                                       reset,
   writeback_stage_nlane_if.slave                     exe_i,
   input  logic [CKPT_LOG-1:0]                        br_ckpt_i,
   input  logic [CTI_W-1:0]                           br_cti_i,
   input  logic [PC_W-1:0]                            br_target_i,
   input  logic                                       br_dir_i,
   input  logic [AL_W:0]                              ldviol_i,
   output logic [NUM_LANES-1:0]                       wb_valid_o,
   output logic [NUM_LANES-1:0][AL_W+WB_FLAGS_W-1:0]  wb_ctrl_o,
   output logic [NUM_LANES-1:0]                       byp_valid_o,
   output logic [NUM_LANES-1:0][PHYS_W-1:0]           byp_phys_o,
   output logic [NUM_LANES-1:0][DATA_W-1:0]           byp_data_o,
   output logic                                       agen_free_valid_o,
   output logic [IQ_W-1:0]                            agen_free_iq_o,
   output logic                                       ctrl_verified_o,
   output logic                                       ctrl_mispredict_o,
   output logic                                       ctrl_conditional_o,
   output logic [CKPT_LOG-1:0]                        ctrl_ckpt_o,
   output logic [CTI_W-1:0]                           ctrl_cti_o,
   output logic [PC_W-1:0]                            ctrl_target_o,
   output logic                                       ctrl_dir_o,
   output logic [AL_W:0]                              ldviol_o,
   output logic                                       squash_active_o,
   output logic [CNT_W-1:0]                           wb_count_o
);

   localparam int SQ_CNT_W = $clog2(SQUASH_CYCLES + 1);

   logic [NUM_LANES-1:0]              laneValid;
   logic [NUM_LANES-1:0][CKPT-1:0]    laneMask;
   logic [NUM_LANES-1:0][FLAGS_W-1:0] laneFlags;
   logic [NUM_LANES-1:0][PHYS_W-1:0]  lanePhys;
   logic [NUM_LANES-1:0][AL_W-1:0]    laneAl;
   logic [NUM_LANES-1:0][IQ_W-1:0]    laneIq;
   logic [NUM_LANES-1:0][DATA_W-1:0]  laneData;

   logic [CKPT_LOG-1:0] brCkpt_q;
   logic [CTI_W-1:0]    brCti_q;
   logic [PC_W-1:0]     brTarget_q;
   logic                brDir_q;
   logic [AL_W:0]       ldviol_q;

   squashState_e        state_q;
   logic [CKPT_LOG-1:0] sqCkpt_q;
   logic [SQ_CNT_W-1:0] sqCnt_q;
   logic                squashActive_q;

   logic [CNT_W-1:0]     count_q, count_d, wbPop;
   logic                 ver, mis;
   logic [CKPT-1:0]      ckptOneHot, sqOneHot, clrMask, dropMask;
   logic [NUM_LANES-1:0] squashVec;
   logic                 unusedLaneBits;

   for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
      wb_lane_reg #(
         .CKPT    (CKPT),
         .FLAGS_W (FLAGS_W),
         .PHYS_W  (PHYS_W),
         .AL_W    (AL_W),
         .IQ_W    (IQ_W),
         .DATA_W  (DATA_W)
      ) uLane (
         .clk        (clk),
         .reset      (reset),
         .valid_i    (exe_i.valid[g]),
         .mask_i     (exe_i.mask[g]),
         .flags_i    (exe_i.flags[g]),
         .phys_i     (exe_i.phys[g]),
         .al_i       (exe_i.al[g]),
         .iq_i       (exe_i.iq[g]),
         .data_i     (exe_i.data[g]),
         .clrMask_i  (clrMask),
         .dropMask_i (dropMask),
         .valid_o    (laneValid[g]),
         .mask_o     (laneMask[g]),
         .flags_o    (laneFlags[g]),
         .phys_o     (lanePhys[g]),
         .al_o       (laneAl[g]),
         .iq_o       (laneIq[g]),
         .data_o     (laneData[g])
      );
   end

   assign ver        = laneValid[CTRL_LANE];
   assign mis        = ver & laneFlags[CTRL_LANE][FLG_MISPRED];
   assign ckptOneHot = CKPT'(1) << brCkpt_q;
   assign sqOneHot   = CKPT'(1) << sqCkpt_q;
   assign clrMask    = (ver && !mis) ? ckptOneHot : '0;

   // Arrivals are filtered in the mispredict cycle itself as well as for the whole SQUASH window.
   assign dropMask   = (mis ? ckptOneHot : '0) | ((state_q == SQUASH) ? sqOneHot : '0);

   always_comb begin
      squashVec   = '0;
      wb_valid_o  = '0;
      byp_valid_o = '0;
      wb_ctrl_o   = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         squashVec[i]   = mis && (|(laneMask[i] & ckptOneHot)) && (i != CTRL_LANE);
         wb_valid_o[i]  = laneValid[i] & ~squashVec[i];
         byp_valid_o[i] = laneValid[i] & laneFlags[i][FLG_DEST] & ~squashVec[i];
         wb_ctrl_o[i]   = {laneAl[i], laneFlags[i][WB_FLAGS_W-1:0]};
      end
   end

   assign byp_phys_o = lanePhys;
   assign byp_data_o = laneData;

   // The IQ entry is released even when the LSU result itself is squashed.
   assign agen_free_valid_o = laneValid[LSU_LANE];
   assign agen_free_iq_o    = laneIq[LSU_LANE];

   always_ff @(posedge clk) begin
      if (reset) begin
         brCkpt_q   <= '0;
         brCti_q    <= '0;
         brTarget_q <= '0;
         brDir_q    <= 1'b0;
         ldviol_q   <= '0;
      end else begin
         if (exe_i.valid[CTRL_LANE]) begin
            brCkpt_q   <= br_ckpt_i;
            brCti_q    <= br_cti_i;
            brTarget_q <= br_target_i;
            brDir_q    <= br_dir_i;
         end
         if (exe_i.valid[LSU_LANE]) begin
            ldviol_q <= ldviol_i;
         end
      end
   end

   assign ctrl_verified_o    = ver;
   assign ctrl_mispredict_o  = mis;
   assign ctrl_conditional_o = ver & laneFlags[CTRL_LANE][FLG_COND];
   assign ctrl_ckpt_o        = brCkpt_q;
   assign ctrl_cti_o         = brCti_q;
   assign ctrl_target_o      = brTarget_q;
   assign ctrl_dir_o         = brDir_q;
   assign ldviol_o           = ldviol_q;

   // A fresh mispredict always restarts the window on its own checkpoint, whatever the current state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         sqCkpt_q       <= '0;
         sqCnt_q        <= '0;
         squashActive_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mis) begin
                  state_q        <= SQUASH;
                  sqCkpt_q       <= brCkpt_q;
                  sqCnt_q        <= SQ_CNT_W'(SQUASH_CYCLES);
                  squashActive_q <= 1'b1;
               end
            end
            SQUASH: begin
               if (mis) begin
                  sqCkpt_q <= brCkpt_q;
                  sqCnt_q  <= SQ_CNT_W'(SQUASH_CYCLES);
               end else if (sqCnt_q == SQ_CNT_W'(1)) begin
                  state_q        <= IDLE;
                  sqCnt_q        <= '0;
                  squashActive_q <= 1'b0;
               end else begin
                  sqCnt_q <= sqCnt_q - SQ_CNT_W'(1);
               end
            end
            default: begin
               state_q        <= IDLE;
               squashActive_q <= 1'b0;
            end
         endcase
      end
   end

   assign squash_active_o = squashActive_q;

   // The visible count already includes this cycle's writebacks.
   always_comb begin
      wbPop = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         wbPop = wbPop + CNT_W'(wb_valid_o[i]);
      end
      count_d = count_q + wbPop;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign wb_count_o     = count_d;
   assign unusedLaneBits = ^{laneIq, laneFlags};

endmodule

// File: tb/tb_writeback_stage_nlane.sv
// Directed bench for writeback_stage_nlane: verify, squash window, mask clearing and counter wrap.
module tb_writeback_stage_nlane;

   localparam int NUM_LANES = 4;
   localparam int CTRL_LANE = 2;
   localparam int LSU_LANE  = 3;
   localparam int DATA_W    = 32;
   localparam int PHYS_W    = 7;
   localparam int AL_W      = 7;
   localparam int IQ_W      = 5;
   localparam int CKPT      = 4;
   localparam int CKPT_LOG  = 2;
   localparam int CTI_W     = 4;
   localparam int PC_W      = 32;
   localparam int FLAGS_W   = 6;
   localparam int WB_FLAGS_W = 4;
   localparam int CNT_W     = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   writeback_stage_nlane_if #(
      .NUM_LANES (NUM_LANES), .CKPT (CKPT), .FLAGS_W (FLAGS_W), .PHYS_W (PHYS_W),
      .AL_W (AL_W), .IQ_W (IQ_W), .DATA_W (DATA_W)
   ) exeIf ();

   logic [CKPT_LOG-1:0]                       br_ckpt_i;
   logic [CTI_W-1:0]                          br_cti_i;
   logic [PC_W-1:0]                           br_target_i;
   logic                                      br_dir_i;
   logic [AL_W:0]                             ldviol_i;
   logic [NUM_LANES-1:0]                      wb_valid_o;
   logic [NUM_LANES-1:0][AL_W+WB_FLAGS_W-1:0] wb_ctrl_o;
   logic [NUM_LANES-1:0]                      byp_valid_o;
   logic [NUM_LANES-1:0][PHYS_W-1:0]          byp_phys_o;
   logic [NUM_LANES-1:0][DATA_W-1:0]          byp_data_o;
   logic                                      agen_free_valid_o;
   logic [IQ_W-1:0]                           agen_free_iq_o;
   logic                                      ctrl_verified_o, ctrl_mispredict_o, ctrl_conditional_o;
   logic [CKPT_LOG-1:0]                       ctrl_ckpt_o;
   logic [CTI_W-1:0]                          ctrl_cti_o;
   logic [PC_W-1:0]                           ctrl_target_o;
   logic                                      ctrl_dir_o;
   logic [AL_W:0]                             ldviol_o;
   logic                                      squash_active_o;
   logic [CNT_W-1:0]                          wb_count_o;

   writeback_stage_nlane dut (
      .clk                (clk),
      .reset              (reset),
      .exe_i              (exeIf.slave),
      .br_ckpt_i          (br_ckpt_i),
      .br_cti_i           (br_cti_i),
      .br_target_i        (br_target_i),
      .br_dir_i           (br_dir_i),
      .ldviol_i           (ldviol_i),
      .wb_valid_o         (wb_valid_o),
      .wb_ctrl_o          (wb_ctrl_o),
      .byp_valid_o        (byp_valid_o),
      .byp_phys_o         (byp_phys_o),
      .byp_data_o         (byp_data_o),
      .agen_free_valid_o  (agen_free_valid_o),
      .agen_free_iq_o     (agen_free_iq_o),
      .ctrl_verified_o    (ctrl_verified_o),
      .ctrl_mispredict_o  (ctrl_mispredict_o),
      .ctrl_conditional_o (ctrl_conditional_o),
      .ctrl_ckpt_o        (ctrl_ckpt_o),
      .ctrl_cti_o         (ctrl_cti_o),
      .ctrl_target_o      (ctrl_target_o),
      .ctrl_dir_o         (ctrl_dir_o),
      .ldviol_o           (ldviol_o),
      .squash_active_o    (squash_active_o),
      .wb_count_o         (wb_count_o)
   );

   int checkCount = 0;
   int failCount  = 0;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic clearInputs();
      exeIf.valid = '0;
      exeIf.mask  = '0;
      exeIf.flags = '0;
      exeIf.phys  = '0;
      exeIf.al    = '0;
      exeIf.iq    = '0;
      exeIf.data  = '0;
      br_ckpt_i   = '0;
      br_cti_i    = '0;
      br_target_i = '0;
      br_dir_i    = 1'b0;
      ldviol_i    = '0;
   endtask

   task automatic setLane(input int lane, input logic [CKPT-1:0] mask, input logic [FLAGS_W-1:0] flags);
      exeIf.valid[lane] = 1'b1;
      exeIf.mask[lane]  = mask;
      exeIf.flags[lane] = flags;
   endtask

   // Push the staged inputs through one edge, sample just after it, then return to idle.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      clearInputs();
   endtask

   initial begin
      reset       = 1'b1;
      exeIf.valid = 'x;
      exeIf.mask  = 'x;
      exeIf.flags = 'x;
      exeIf.phys  = 'x;
      exeIf.al    = 'x;
      exeIf.iq    = 'x;
      exeIf.data  = 'x;
      br_ckpt_i   = 'x;
      br_cti_i    = 'x;
      br_target_i = 'x;
      br_dir_i    = 'x;
      ldviol_i    = 'x;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_wb_valid", wb_valid_o, 0);
      checkOutput("rst_squash", squash_active_o, 0);
      checkOutput("rst_count", wb_count_o, 0);
      clearInputs();
      reset = 1'b0;
      applyStimulus();
      checkOutput("post_rst_wb_valid", wb_valid_o, 0);
      checkOutput("post_rst_byp_valid", byp_valid_o, 0);
      checkOutput("post_rst_agen", agen_free_valid_o, 0);
      checkOutput("post_rst_mispredict", ctrl_mispredict_o, 0);
      checkOutput("post_rst_ldviol", ldviol_o, 0);
      checkOutput("post_rst_count", wb_count_o, 0);

      // Plain writeback on lanes 0, 1 and the LSU lane.
      setLane(0, 4'b0000, 6'b010000);
      setLane(1, 4'b0000, 6'b010000);
      setLane(3, 4'b0000, 6'b010110);
      exeIf.phys[1] = 7'h21;
      exeIf.data[1] = 32'hDEAD_0001;
      exeIf.al[3]   = 7'h12;
      exeIf.iq[3]   = 5'd9;
      ldviol_i      = 8'h85;
      applyStimulus();
      checkOutput("basic_wb_valid", wb_valid_o, 4'b1011);
      checkOutput("basic_byp_valid", byp_valid_o, 4'b1011);
      checkOutput("basic_count", wb_count_o, 3);
      checkOutput("basic_byp_phys1", byp_phys_o[1], 7'h21);
      checkOutput("basic_byp_data1", byp_data_o[1], 32'hDEAD_0001);
      checkOutput("basic_wb_ctrl3", wb_ctrl_o[3], 11'h126);
      checkOutput("basic_agen_valid", agen_free_valid_o, 1);
      checkOutput("basic_agen_iq", agen_free_iq_o, 9);
      checkOutput("basic_ldviol", ldviol_o, 8'h85);
      applyStimulus();
      checkOutput("idle_wb_valid", wb_valid_o, 0);
      checkOutput("idle_count", wb_count_o, 3);
      checkOutput("idle_ldviol_hold", ldviol_o, 8'h85);

      // Mispredict on checkpoint 1: lane0 depends on it, lane1 does not.
      setLane(CTRL_LANE, 4'b0000, 6'b100001);
      br_ckpt_i   = 2'd1;
      br_cti_i    = 4'd3;
      br_target_i = 32'h0000_1000;
      br_dir_i    = 1'b1;
      setLane(0, 4'b0010, 6'b010000);
      setLane(1, 4'b0001, 6'b010000);
      applyStimulus();
      checkOutput("mis_wb_valid", wb_valid_o, 4'b0110);
      checkOutput("mis_byp_valid", byp_valid_o, 4'b0010);
      checkOutput("mis_flag", ctrl_mispredict_o, 1);
      checkOutput("mis_verified", ctrl_verified_o, 1);
      checkOutput("mis_conditional", ctrl_conditional_o, 1);
      checkOutput("mis_ckpt", ctrl_ckpt_o, 1);
      checkOutput("mis_cti", ctrl_cti_o, 3);
      checkOutput("mis_target", ctrl_target_o, 32'h0000_1000);
      checkOutput("mis_dir", ctrl_dir_o, 1);
      checkOutput("mis_squash_not_yet", squash_active_o, 0);
      checkOutput("mis_count", wb_count_o, 5);
      applyStimulus();
      checkOutput("win0_squash", squash_active_o, 1);
      checkOutput("win0_mis_clear", ctrl_mispredict_o, 0);
      setLane(0, 4'b0010, 6'b010000);
      applyStimulus();
      checkOutput("win1_wb_valid", wb_valid_o, 0);
      checkOutput("win1_squash", squash_active_o, 1);
      setLane(0, 4'b0010, 6'b010000);
      applyStimulus();
      checkOutput("win2_wb_valid", wb_valid_o, 0);
      checkOutput("win2_squash", squash_active_o, 0);
      setLane(0, 4'b0010, 6'b010000);
      applyStimulus();
      checkOutput("after_win_wb_valid", wb_valid_o, 4'b0001);
      checkOutput("after_win_count", wb_count_o, 6);

      // Correct verify on ckpt 2 clears bit 2 from lane1's arriving packet.
      setLane(CTRL_LANE, 4'b0000, 6'b000000);
      br_ckpt_i = 2'd2;
      setLane(1, 4'b0100, 6'b010000);
      applyStimulus();
      checkOutput("ver_wb_valid", wb_valid_o, 4'b0110);
      checkOutput("ver_verified", ctrl_verified_o, 1);
      checkOutput("ver_not_mis", ctrl_mispredict_o, 0);
      checkOutput("ver_not_cond", ctrl_conditional_o, 0);
      setLane(CTRL_LANE, 4'b0000, 6'b000001);
      br_ckpt_i = 2'd2;
      setLane(1, 4'b0100, 6'b010000);
      applyStimulus();
      checkOutput("clr_wb_valid", wb_valid_o, 4'b0110);
      checkOutput("clr_mis", ctrl_mispredict_o, 1);
      checkOutput("clr_count", wb_count_o, 10);

      // Second mispredict (ckpt 3) lands while the window for ckpt 2 is open.
      setLane(CTRL_LANE, 4'b1000, 6'b000001);
      br_ckpt_i = 2'd3;
      applyStimulus();
      checkOutput("mis2_ctrl_kept", wb_valid_o, 4'b0100);
      checkOutput("mis2_flag", ctrl_mispredict_o, 1);
      checkOutput("mis2_squash", squash_active_o, 1);
      applyStimulus();
      checkOutput("reload_w0_squash", squash_active_o, 1);
      setLane(0, 4'b1000, 6'b010000);
      setLane(1, 4'b0100, 6'b010000);
      applyStimulus();
      checkOutput("reload_filter", wb_valid_o, 4'b0010);
      checkOutput("reload_w1_squash", squash_active_o, 1);
      checkOutput("reload_count", wb_count_o, 12);
      applyStimulus();
      checkOutput("reload_end_squash", squash_active_o, 0);

      // Counter wrap: fill to 2^CNT_W-2, then four more writebacks.
      reset = 1'b1;
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      applyStimulus();
      checkOutput("wrap_start_count", wb_count_o, 0);
      for (int n = 0; n < 16383; n++) begin
         for (int l = 0; l < NUM_LANES; l++) setLane(l, 4'b0000, 6'b000000);
         applyStimulus();
      end
      setLane(0, 4'b0000, 6'b000000);
      setLane(1, 4'b0000, 6'b000000);
      applyStimulus();
      checkOutput("wrap_near_top", wb_count_o, 16'hFFFE);
      for (int l = 0; l < NUM_LANES; l++) setLane(l, 4'b0000, 6'b000000);
      applyStimulus();
      checkOutput("wrap_wb_valid", wb_valid_o, 4'b1111);
      checkOutput("wrap_count", wb_count_o, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
